// File: rtl/sfx_pkg.sv
// Shared definitions for the sfx_synth sound-effect generator.
// Latency: n/a (types, constants and the LFSR step function only).
// Backpressure: n/a.
package sfx_pkg;

  localparam logic [1:0] WAVE_SQUARE = 2'd0;
  localparam logic [1:0] WAVE_TRI    = 2'd1;
  localparam logic [1:0] WAVE_SAW    = 2'd2;
  localparam logic [1:0] WAVE_NOISE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } env_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/sfx_osc.sv
// One oscillator channel: phase accumulator, noise LFSR and waveform select.
// Latency: 1 cycle from phase/LFSR state to the registered sample.
// Backpressure: none, free-running every cycle.
module sfx_osc
  import sfx_pkg::*;
#(
  parameter int PHASE_W = 22,
  parameter int AMP_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] tune,
  input  logic [1:0]         wave_sel,
  output logic [AMP_W-1:0]   sample
);

  logic [PHASE_W-1:0] phase;
  logic [15:0]        lfsr;
  logic               msb;
  logic               msb_q;
  logic [AMP_W-1:0]   ramp;
  logic [AMP_W-1:0]   tri_up;
  logic [AMP_W-1:0]   wave;

  assign msb    = phase[PHASE_W-1];
  assign ramp   = phase[PHASE_W-1 -: AMP_W];
  // Triangle folds the ramp: doubled lower bits, inverted in the second half-period
  assign tri_up = {phase[PHASE_W-2 -: AMP_W-1], 1'b0};

  always_comb begin
    wave = ramp;
    case (wave_sel)
      WAVE_SQUARE: wave = {AMP_W{msb}};
      WAVE_TRI:    wave = msb ? ~tri_up : tri_up;
      WAVE_SAW:    wave = ramp;
      WAVE_NOISE:  wave = lfsr[AMP_W-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= '0;
      lfsr   <= LFSR_SEED;
      msb_q  <= 1'b0;
      sample <= '0;
    end else begin
      phase  <= phase + tune;
      msb_q  <= msb;
      if (msb && !msb_q)
        lfsr <= lfsr_step(lfsr);
      sample <= wave;
    end
  end

endmodule

// File: rtl/sfx_synth.sv
// Multi-channel oscillator mix scaled by a triggered AHR envelope, output as PWM.
// Latency: 3 pipeline stages from phase to scaled, then duty latched at PWM wrap, a_out +1 cycle.
// Backpressure: none; start is a one-cycle trigger that also retriggers.
module sfx_synth
  import sfx_pkg::*;
#(
  parameter int N_CH         = 2,
  parameter int PHASE_W      = 22,
  parameter int AMP_W        = 8,
  parameter int PWM_W        = 8,
  parameter int ENV_DIV      = 10_000,
  parameter int ATTACK_STEP  = 8,
  parameter int RELEASE_STEP = 2,
  parameter int HOLD_TICKS   = 50
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N_CH*PHASE_W-1:0] tune,
  input  logic [2*N_CH-1:0]       wave_sel,
  output logic                    busy,
  output logic                    gain,
  output logic                    shut_down_n,
  output logic                    a_out
);

  localparam int SUM_W  = AMP_W + 2;
  localparam int MIX_SH = $clog2(N_CH);
  localparam int PRE_W  = $clog2(ENV_DIV);
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [AMP_W-1:0] ENV_MAX  = '1;
  localparam logic [AMP_W:0]   ATK_STEP = (AMP_W+1)'(ATTACK_STEP);
  localparam logic [AMP_W-1:0] REL_STEP = AMP_W'(RELEASE_STEP);

  logic [AMP_W-1:0]  samples [N_CH];
  logic [SUM_W-1:0]  sum;
  logic [AMP_W-1:0]  mix;
  logic [AMP_W-1:0]  scaled;
  logic [AMP_W-1:0]  env;
  logic [AMP_W:0]    env_up;
  logic [PWM_W-1:0]  pwm_cnt;
  logic [PWM_W-1:0]  duty;
  logic [PWM_W-1:0]  duty_src;
  logic [PRE_W-1:0]  pre;
  logic [HOLD_W-1:0] hold_cnt;
  logic              tick;
  env_state_t        state;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    sfx_osc #(
      .PHASE_W(PHASE_W),
      .AMP_W  (AMP_W)
    ) u_osc (
      .clk     (clk),
      .rst     (rst),
      .tune    (tune[k*PHASE_W +: PHASE_W]),
      .wave_sel(wave_sel[2*k +: 2]),
      .sample  (samples[k])
    );
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < N_CH; k++)
      sum = sum + SUM_W'(samples[k]);
  end

  if (PWM_W <= AMP_W) begin : g_duty_msb
    assign duty_src = scaled[AMP_W-1 -: PWM_W];
  end else begin : g_duty_pad
    assign duty_src = {scaled, {(PWM_W-AMP_W){1'b0}}};
  end

  assign tick        = (pre == PRE_W'(ENV_DIV - 1));
  assign env_up      = {1'b0, env} + ATK_STEP;
  assign gain        = 1'b0;
  assign shut_down_n = busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      mix     <= '0;
      scaled  <= '0;
      pwm_cnt <= '0;
      duty    <= '0;
      a_out   <= 1'b0;
    end else begin
      mix     <= AMP_W'(sum >> MIX_SH);
      scaled  <= AMP_W'(((2*AMP_W)'(mix) * (2*AMP_W)'(env)) >> AMP_W);
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      // Duty only changes at the period boundary so each PWM period is glitch-free
      if (pwm_cnt == '0)
        duty <= (state == IDLE) ? '0 : duty_src;
      a_out   <= (pwm_cnt < duty);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start)
      pre <= '0;
    else
      pre <= tick ? '0 : pre + PRE_W'(1);
  end

  // Retrigger keeps env where it is so a restart never clicks
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      env      <= '0;
      hold_cnt <= '0;
      busy     <= 1'b0;
    end else if (start) begin
      state    <= ATTACK;
      hold_cnt <= '0;
      busy     <= 1'b1;
    end else if (tick) begin
      case (state)
        IDLE: env <= '0;
        ATTACK: begin
          if (env_up >= {1'b0, ENV_MAX}) begin
            env      <= ENV_MAX;
            state    <= HOLD;
            hold_cnt <= '0;
          end else begin
            env <= env_up[AMP_W-1:0];
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_W'(HOLD_TICKS - 1))
            state <= RELEASE;
          else
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
        RELEASE: begin
          if (env <= REL_STEP) begin
            env   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            env <= env - REL_STEP;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfx_synth.sv
// Randomised and directed bench for sfx_synth against a cycle-level arithmetic model.
module tb_sfx_synth;

  localparam int N_CH         = 2;
  localparam int PHASE_W      = 22;
  localparam int AMP_W        = 8;
  localparam int PWM_W        = 8;
  localparam int ENV_DIV      = 4;
  localparam int ATTACK_STEP  = 64;
  localparam int RELEASE_STEP = 64;
  localparam int HOLD_TICKS   = 3;

  localparam int S_IDLE = 0;
  localparam int S_ATK  = 1;
  localparam int S_HOLD = 2;
  localparam int S_REL  = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [N_CH*PHASE_W-1:0] tune;
  logic [2*N_CH-1:0]       wave_sel;
  logic                    busy;
  logic                    gain;
  logic                    shut_down_n;
  logic                    a_out;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  int m_phase[N_CH];
  int m_mprev[N_CH];
  int m_lfsr[N_CH];
  int m_samp[N_CH];
  int m_mix, m_scaled, m_cnt, m_duty, m_aout;
  int m_st, m_env, m_pre, m_hold;

  sfx_synth #(
    .N_CH(N_CH), .PHASE_W(PHASE_W), .AMP_W(AMP_W), .PWM_W(PWM_W),
    .ENV_DIV(ENV_DIV), .ATTACK_STEP(ATTACK_STEP), .RELEASE_STEP(RELEASE_STEP),
    .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .tune(tune), .wave_sel(wave_sel),
    .busy(busy), .gain(gain), .shut_down_n(shut_down_n), .a_out(a_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic int lfsr_ref(input int s);
    return (s & 1) ? ((s >> 1) ^ 'hB400) : (s >> 1);
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < N_CH; ch++) begin
      m_phase[ch] = 0; m_mprev[ch] = 0; m_lfsr[ch] = 'hACE1; m_samp[ch] = 0;
    end
    m_mix = 0; m_scaled = 0; m_cnt = 0; m_duty = 0; m_aout = 0;
    m_st = S_IDLE; m_env = 0; m_pre = 0; m_hold = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_step();
    int tick, n_mix, n_scaled, n_duty, n_aout, tk, ws, t, m, dbl;
    if (rst) begin
      model_reset();
      return;
    end
    tick     = (m_pre == ENV_DIV - 1);
    n_mix    = (m_samp[0] + m_samp[1]) / 2;
    n_scaled = (m_mix * m_env) / 256;
    n_duty   = (m_cnt == 0) ? ((m_st == S_IDLE) ? 0 : m_scaled) : m_duty;
    n_aout   = (m_cnt < m_duty) ? 1 : 0;
    for (int ch = 0; ch < N_CH; ch++) begin
      tk  = int'(tune[ch*PHASE_W +: PHASE_W]);
      ws  = int'(wave_sel[ch*2 +: 2]);
      t   = m_phase[ch] / (1 << 14);
      m   = m_phase[ch] / (1 << 21);
      dbl = (t * 2) % 256;
      case (ws)
        0:       m_samp[ch] = m ? 255 : 0;
        1:       m_samp[ch] = m ? 255 - dbl : dbl;
        2:       m_samp[ch] = t;
        default: m_samp[ch] = m_lfsr[ch] % 256;
      endcase
      if (m == 1 && m_mprev[ch] == 0) m_lfsr[ch] = lfsr_ref(m_lfsr[ch]);
      m_mprev[ch] = m;
      m_phase[ch] = (m_phase[ch] + tk) % (1 << 22);
    end
    if (start) begin
      m_st = S_ATK; m_hold = 0; m_pre = 0;
    end else begin
      if (tick) begin
        case (m_st)
          S_ATK: begin
            m_env = (m_env + ATTACK_STEP > 255) ? 255 : m_env + ATTACK_STEP;
            if (m_env == 255) begin m_st = S_HOLD; m_hold = 0; end
          end
          S_HOLD: begin
            m_hold++;
            if (m_hold == HOLD_TICKS) m_st = S_REL;
          end
          S_REL: begin
            m_env = (m_env < RELEASE_STEP) ? 0 : m_env - RELEASE_STEP;
            if (m_env == 0) m_st = S_IDLE;
          end
          default: ;
        endcase
      end
      m_pre = tick ? 0 : m_pre + 1;
    end
    m_mix = n_mix; m_scaled = n_scaled; m_duty = n_duty; m_aout = n_aout;
    m_cnt = (m_cnt + 1) % 256;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("a_out", a_out, m_aout);
    check("busy", busy, m_st != S_IDLE);
    check("shut_down_n", shut_down_n, m_st != S_IDLE);
    check("gain", gain, 0);
    check("env", dut.env, m_env);
  endtask

  task automatic wait_latch();
    int i = 0;
    while (m_cnt != 1 && i < 300) begin
      start = (i % 8 == 0);
      cycle();
      start = 1'b0;
      i++;
    end
    check("latch_align", dut.pwm_cnt, 1);
  endtask

  task automatic sq_window(input string tag);
    int exp_d, highs;
    exp_d = m_duty;
    highs = 0;
    check({tag, "_duty"}, dut.duty, exp_d);
    for (int i = 0; i < 256; i++) begin
      start = (i % 8 == 0);
      cycle();
      start = 1'b0;
      highs += int'(a_out);
    end
    check(tag, highs, exp_d);
  endtask

  initial begin
    int env_tab[11];
    int prev, cur, first, changes, highs;
    env_tab = '{64, 128, 192, 255, 255, 255, 255, 191, 127, 63, 0};
    model_reset();

    // reset held with start asserted
    rst = 1'b1; start = 1'b1; tune = '0; wave_sel = {2'd2, 2'd2};
    repeat (3) cycle();
    rst = 1'b0; start = 1'b0;
    cycle();

    // full envelope with zero tune sawtooth: mix and a_out must stay 0
    highs = 0;
    start = 1'b1; cycle(); start = 1'b0;
    check("busy_rise", busy, 1);
    for (int k = 1; k <= 11; k++) begin
      for (int c = 0; c < 4; c++) begin
        cycle();
        highs += int'(a_out);
      end
      check($sformatf("env_tick%0d", k), dut.env, env_tab[k-1]);
      check($sformatf("busy_tick%0d", k), busy, (k < 11) ? 1 : 0);
      check("zero_mix", dut.mix, 0);
    end
    check("zero_tune_aout", highs, 0);

    // retrigger during release at env 127
    start = 1'b1; cycle(); start = 1'b0;
    repeat (36) cycle();
    check("retrig_pre_env", dut.env, 127);
    repeat (2) cycle();
    start = 1'b1; cycle(); start = 1'b0;
    repeat (4) cycle();
    check("retrig_env", dut.env, 191);
    check("retrig_state", dut.state, sfx_pkg::ATTACK);
    check("retrig_busy", busy, 1);
    repeat (60) cycle();

    // full-scale in-phase squares with env held at max by periodic retrigger
    rst = 1'b1; tune = {22'h200000, 22'h200000}; wave_sel = 4'b0000;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      start = (i % 8 == 0); cycle(); start = 1'b0;
    end
    wait_latch();
    sq_window("square_a");
    sq_window("square_b");
    tune = '0; cycle(); tune = {22'h200000, 22'h200000};
    wait_latch();
    sq_window("square_c");

    // noise: LFSR steps once per 4 cycles
    rst = 1'b1; tune = {22'h100000, 22'h100000}; wave_sel = 4'b1111;
    cycle();
    rst = 1'b0;
    check("lfsr_seed", dut.g_ch[0].u_osc.lfsr, 'hACE1);
    prev = 'hACE1; first = -1; changes = 0;
    for (int i = 0; i < 40; i++) begin
      start = (i == 0); cycle(); start = 1'b0;
      cur = int'(dut.g_ch[0].u_osc.lfsr);
      if (cur != prev) begin
        changes++;
        if (first < 0) first = cur;
      end
      prev = cur;
    end
    check("lfsr_first", first, lfsr_ref('hACE1));
    check("lfsr_steps", changes, 10);

    // randomised traffic
    for (int i = 0; i < 8000; i++) begin
      rst   = ($urandom_range(0, 599) == 0);
      start = ($urandom_range(0, 39) == 0);
      if (i % 150 == 0)
        for (int ch = 0; ch < N_CH; ch++)
          tune[ch*PHASE_W +: PHASE_W] = ($urandom_range(0, 4) == 0) ? '0 : PHASE_W'($urandom);
      if (i % 97 == 0) wave_sel = 4'($urandom);
      cycle();
    end
    rst = 1'b0; start = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sfx_synth.md
Name: sfx_synth

Overview:
- Parametrised multi-channel sound-effect generator: the next generation of the single-purpose whistle tone path.
- N_CH phase-accumulator oscillators, each with a selectable waveform, are averaged and scaled by a triggered attack/hold/release envelope, then driven out as PWM to the board audio amplifier.
- Runs entirely on one clock using clock enables (no derived clocks). Game logic triggers it with a start pulse.

Parameters:
- N_CH, 2, number of oscillator channels; legal values 1, 2, 4.
- PHASE_W, 22, phase accumulator and tuning word width.
- AMP_W, 8, waveform sample, mix and envelope width.
- PWM_W, 8, PWM counter width; one PWM period = 2^PWM_W clk cycles.
- ENV_DIV, 10_000, clk cycles per envelope tick; must be >= 2.
- ATTACK_STEP, 8, envelope increment per tick in ATTACK.
- RELEASE_STEP, 2, envelope decrement per tick in RELEASE.
- HOLD_TICKS, 50, ticks spent in HOLD.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle trigger; also retriggers while a sound is playing.
- tune  in  N_CH*PHASE_W  per-channel tuning word; channel k is at bits [k*PHASE_W +: PHASE_W].
- wave_sel  in  2*N_CH  per-channel waveform; 0 square, 1 triangle, 2 sawtooth, 3 noise.
- busy  out  1  high whenever the envelope FSM is not in IDLE.
- gain  out  1  constant 0.
- shut_down_n  out  1  equals busy, so the amplifier is off while idle.
- a_out  out  1  PWM audio output.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): all phase accumulators 0; LFSRs 16'hACE1; env 0; FSM IDLE; PWM counter 0; latched duty 0.
- Outputs at reset: a_out=0, busy=0, shut_down_n=0. A reset mid-sound aborts to IDLE on the same edge.
- Oscillator k:
  - Every cycle, phase += tune_k, modulo 2^PHASE_W (wraps silently).
  - t = phase[PHASE_W-1 -: AMP_W]; m = phase MSB.
  - Square = all bits equal to m.
  - Sawtooth = t.
  - Triangle = m ? ~{t[AMP_W-2:0],0} : {t[AMP_W-2:0],0}.
  - Noise = LFSR[AMP_W-1:0]. The LFSR uses polynomial x^16+x^14+x^13+x^11+1 and shifts once on each 0->1 transition of m.
  - tune_k=0 freezes the channel at its current value.
- Pipeline:
  - Stage 1 registers the per-channel waveforms.
  - Stage 2 registers mix = (sum of channels) >> log2(N_CH). The sum is computed at AMP_W+2 bits, so there is no overflow.
  - Stage 3 registers scaled = (mix * env) >> AMP_W, computed at full 2*AMP_W product width.
- PWM:
  - The counter free-runs 0..2^PWM_W-1.
  - When the counter equals 0, duty <= scaled[AMP_W-1 -: PWM_W]. If PWM_W > AMP_W, scaled is zero-extended on the LSB side instead.
  - a_out = (counter < duty) registered, giving 1 cycle latency. duty=0 gives constant 0.
  - In IDLE, duty is forced to 0 at the next latch point.
- Envelope tick: a prescaler counts 0..ENV_DIV-1 and asserts tick for one cycle at ENV_DIV-1. The prescaler is cleared on reset and on start.
- FSM states and transitions:
  - IDLE: env=0. On start -> ATTACK.
  - ATTACK: on each tick, env = min(env+ATTACK_STEP, 2^AMP_W-1). When it reaches max -> HOLD and the hold counter clears.
  - HOLD: env at max. Counts ticks; after HOLD_TICKS ticks -> RELEASE.
  - RELEASE: on each tick, env = max(env-RELEASE_STEP, 0). When it reaches 0 -> IDLE.
- Retrigger: start in ATTACK, HOLD or RELEASE -> ATTACK. env continues from its current value (no click). The hold counter clears.
- Simultaneous events:
  - start and tick on the same cycle: start wins and no env step occurs.
  - start and rst on the same cycle: rst wins.
- busy and shut_down_n go high on the edge after start and fall on the edge that enters IDLE.
- Oscillators run continuously regardless of FSM state; wave_sel and tune may change at any time.

Decomposition:
- Shared package sfx_pkg holds:
  - wave codes WAVE_SQUARE=0, WAVE_TRI=1, WAVE_SAW=2, WAVE_NOISE=3;
  - FSM state encoding IDLE/ATTACK/HOLD/RELEASE;
  - LFSR seed 16'hACE1 and tap mask.
- One sub-module, sfx_osc (phase accumulator, LFSR and waveform mux, parametrised by PHASE_W and AMP_W), instantiated N_CH times via generate.
- Envelope FSM, mixer and PWM stay in the top level.

Test Plan (all scenarios use ENV_DIV=4, PWM_W=AMP_W=8, HOLD_TICKS=3, ATTACK_STEP=64, RELEASE_STEP=64, N_CH=2):
- Reset: hold rst 3 cycles with start=1 -> a_out=0, busy=0, shut_down_n=0, gain=0 throughout.
- Envelope sequence: one start pulse -> busy rises the next cycle; env sequence 64,128,192,255 then holds 255 for 3 ticks, then 191,127,63,0. busy falls when IDLE is entered, 8 ticks of ramp+release plus 3 hold ticks after start.
- Retrigger: start during RELEASE at env=127 -> next tick env=191, FSM back in ATTACK, busy stays high.
- Full-scale square: ch0 square and ch1 square, both with tune=2^21 (phase MSB toggles every cycle; period 2 cycles) during HOLD -> mix alternates 255/0 and duty latches 254 or 0 at each PWM wrap. Check the a_out high-count per period equals the latched duty.
- Zero tune: tune=0 on both channels with sawtooth -> mix stays 0 and a_out stays 0 during HOLD.
- Noise: wave_sel=3 with tune=2^20 -> the LFSR advances exactly once per 4 cycles; its first state after 16'hACE1 matches the reference polynomial model.
